alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Sequenced N-bit ALU controller: accepts one operation per start/busy handshake, runs it, presents a registered result, flags and a one-cycle done pulse.
- Logic ops, add and sub complete in one cycle.
- Multiply is iterative shift-add; divide and mod share one iterative restoring divider, N cycles each.
- Sits between the operation source (FSM/register file) and the result consumer; replaces the purely combinational function units with one shared, timed resource.

Parameters:
N, 8, operand width in bits (N >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only at a rising edge where busy=0
op  input  4  operation code, sampled with start
a  input  N  operand A, sampled with start
b  input  N  operand B, sampled with start
busy  output  1  high from the edge after acceptance until the edge that raises done
done  output  1  one-cycle pulse: result and flags valid
result  output  N  low N bits of result
result_hi  output  N  upper N bits of product (MUL only, else 0)
zero  output  1  full result == 0
carry  output  1  ADD carry-out
negative  output  1  SUB borrow (b > a unsigned)
overflow  output  1  MUL: result_hi != 0
div_zero  output  1  DIV/MOD with b == 0
illegal  output  1  unsupported op code

Behaviour:
- Reset (async, any state): FSM -> IDLE. busy, done, result, result_hi and all flags = 0. Iteration counter and internal registers cleared. An in-flight operation is discarded and produces no done.
- Op codes (all unsigned):
  - 0 ADD: {carry,result} = a+b
  - 1 SUB: result = a-b mod 2^N, negative = b>a
  - 2 AND, 3 OR, 4 XOR
  - 5 NOT: result = ~a, b ignored
  - 6 MUL: {result_hi,result} = a*b
  - 7 DIV: result = a/b
  - 8 MOD: result = a%b
  - 9-15: illegal
- States:
  - IDLE: start=1 latches op/a/b.
    - Ops 0-5, illegal, or DIV/MOD with b=0 -> FINISH.
    - MUL -> MUL_IT; DIV/MOD -> DIV_IT. Counter loads N-1.
  - MUL_IT: each cycle, if multiplier LSB=1, add multiplicand to the 2N-bit accumulator, then shift. Counter decrements; at 0 -> FINISH.
  - DIV_IT: restoring step per cycle (shift remainder/quotient, trial subtract, restore on borrow). Counter decrements; at 0 -> FINISH.
  - FINISH: register result and flags, pulse done -> IDLE.
- Latency from the accepting edge k:
  - Single-cycle ops, div-by-zero and illegal: done high after edge k+1.
  - MUL/DIV/MOD: done high after edge k+N+1.
- Next start may be accepted at the same edge on which done falls (back-to-back allowed). Peak throughput is one simple op per 2 cycles.
- start while busy=1 is ignored. No queuing. Latched operands are unaffected by later changes to a, b or op.
- Outputs and flags change only on the done-raising edge, and hold until the next done or reset.
- Flags not relevant to the completed op are driven 0.
- Div-by-zero: result=0, result_hi=0, div_zero=1, zero=1.
- Illegal: result=0, illegal=1, zero=0.
- zero is computed over {result_hi,result} for MUL and over result otherwise.

Test Plan:
- (N=8 for all) Reset mid-MUL at cycle 3 -> busy=0, done never pulses, all outputs 0. Then ADD 0x01+0x02 -> result 0x03, done at k+1.
- ADD 0xFF+0x01 -> result 0x00, carry=1, zero=1. SUB 0x05-0x09 -> result 0xFC, negative=1.
- MUL 200*3 -> result 0x58, result_hi 0x02, overflow=1, done exactly at k+9. MUL 15*17 -> result 0xFF, overflow=0.
- DIV 100/7 -> 14 and MOD 100%7 -> 2, each done at k+9. DIV 5/0 -> result 0, div_zero=1, done at k+1.
- start held high with new operands during a DIV -> ignored, result unchanged. Back-to-back XOR 0xF0^0xFF then NOT 0x0F -> 0x0F then 0xF0, consecutive dones 2 cycles apart.
- op=12 -> illegal=1, result 0, done at k+1. Following AND 0xAA&0x0F -> 0x0A, illegal=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequenced N-bit ALU: one operation per start/busy handshake. Simple ops finish in one cycle.
// MUL uses shift-add and DIV/MOD use a restoring divider; both iterate N cycles over a shared accumulator.
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         zero,
  output logic         carry,
  output logic         negative,
  output logic         overflow,
  output logic         div_zero,
  output logic         illegal
);

  localparam int CW = $clog2(N);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_DIV = 4'd7;
  localparam logic [3:0] OP_MOD = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_r;
  logic [N-1:0]     a_r, b_r;
  logic [2*N-1:0]   acc;
  logic [CW-1:0]    cnt;

  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_next;
  logic [N:0]       div_shift, div_trial;
  logic [2*N-1:0]   div_next;

  logic [N:0]       simple;
  logic [N-1:0]     fin_lo, fin_hi;
  logic             fin_zero, fin_carry, fin_neg, fin_ovf, fin_dz, fin_ill;

  // Single-cycle function unit; bit N carries the ADD carry-out.
  function automatic logic [N:0] simple_op(input logic [3:0] o, input logic [N-1:0] x,
                                           input logic [N-1:0] y);
    case (o)
      OP_ADD:  simple_op = {1'b0, x} + {1'b0, y};
      OP_SUB:  simple_op = {1'b0, x - y};
      OP_AND:  simple_op = {1'b0, x & y};
      OP_OR:   simple_op = {1'b0, x | y};
      OP_XOR:  simple_op = {1'b0, x ^ y};
      OP_NOT:  simple_op = {1'b0, ~x};
      default: simple_op = '0;
    endcase
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL)                                   state_nxt = MUL_IT;
          else if ((op == OP_DIV || op == OP_MOD) && b != '0) state_nxt = DIV_IT;
          else                                                state_nxt = FINISH;
        end
      end
      MUL_IT:  if (cnt == '0) state_nxt = FINISH;
      DIV_IT:  if (cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc = {partial product, multiplier} for MUL and {remainder, quotient} for DIV/MOD.
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? b_r : {N{1'b0}})};
    mul_next  = {mul_sum, acc[N-1:1]};
    div_shift = acc[2*N-1:N-1];
    div_trial = div_shift - {1'b0, b_r};
    div_next  = {(div_trial[N] ? div_shift[N-1:0] : div_trial[N-1:0]),
                 acc[N-2:0], ~div_trial[N]};
  end

  always_comb begin
    simple    = simple_op(op_r, a_r, b_r);
    fin_lo    = simple[N-1:0];
    fin_hi    = '0;
    fin_carry = 1'b0;
    fin_neg   = 1'b0;
    fin_ovf   = 1'b0;
    fin_dz    = 1'b0;
    fin_ill   = 1'b0;
    case (op_r)
      OP_ADD: fin_carry = simple[N];
      OP_SUB: fin_neg = (b_r > a_r);
      OP_AND, OP_OR, OP_XOR, OP_NOT: ;
      OP_MUL: begin
        fin_lo  = acc[N-1:0];
        fin_hi  = acc[2*N-1:N];
        fin_ovf = |acc[2*N-1:N];
      end
      OP_DIV, OP_MOD: begin
        if (b_r == '0) begin
          fin_lo = '0;
          fin_dz = 1'b1;
        end else begin
          fin_lo = (op_r == OP_DIV) ? acc[N-1:0] : acc[2*N-1:N];
        end
      end
      default: begin
        fin_lo  = '0;
        fin_ill = 1'b1;
      end
    endcase
    fin_zero = !fin_ill && ({fin_hi, fin_lo} == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            acc  <= {{N{1'b0}}, a};
            cnt  <= CW'(N - 1);
          end
        end
        MUL_IT: begin
          acc <= mul_next;
          cnt <= cnt - CW'(1);
        end
        DIV_IT: begin
          acc <= div_next;
          cnt <= cnt - CW'(1);
        end
        FINISH: begin
          result    <= fin_lo;
          result_hi <= fin_hi;
          zero      <= fin_zero;
          carry     <= fin_carry;
          negative  <= fin_neg;
          overflow  <= fin_ovf;
          div_zero  <= fin_dz;
          illegal   <= fin_ill;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (N=8): the driver queues the expected responses.
// A negedge monitor pops them on each done pulse and checks the values, flags and completion cycle.
module tb_alu_sequencer;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, zero, carry, negative, overflow, div_zero, illegal;
  logic [N-1:0] result, result_hi;

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow),
    .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] res;
    logic [7:0] hi;
    logic [5:0] fl;   // {zero, carry, negative, overflow, div_zero, illegal}
    int         dcyc;
  } exp_t;

  exp_t sb[$];
  int   done_log[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.nm, ".result"}, 32'(result), 32'(e.res));
        chk({e.nm, ".result_hi"}, 32'(result_hi), 32'(e.hi));
        chk({e.nm, ".flags"}, 32'({zero, carry, negative, overflow, div_zero, illegal}), 32'(e.fl));
        chk({e.nm, ".done_cycle"}, 32'(cyc), 32'(e.dcyc));
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input int lat, input logic [7:0] er, input logic [7:0] eh,
                       input logic [5:0] ef, input bit push, input bit hold);
    exp_t e;
    int   w;
    int   k;
    w = 0;
    @(negedge clk);
    while (busy !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s.wait_idle: busy=%b after 50 cycles, required 0", nm, busy);
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    k = cyc;
    chk({nm, ".accepted_busy"}, 32'(busy), 32'd1);
    if (push) begin
      e.nm = nm;
      e.res = er;
      e.hi = eh;
      e.fl = ef;
      e.dcyc = k + lat;
      sb.push_back(e);
    end
    if (hold) begin
      op = 4'd0;
      a = 8'h01;
      b = 8'h01;
      repeat (5) begin
        chk({nm, ".held_result"}, 32'(result), 32'h02);
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    op = 4'd0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.outputs", 32'({result, result_hi, zero, carry, negative, overflow, div_zero, illegal}), 32'd0);
    rst = 1'b0;

    // MUL aborted by a reset two iterations in: no done must ever appear.
    issue("mul_abort", 4'd6, 8'd200, 8'd3, 9, 8'h00, 8'h00, 6'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.outputs", 32'({done, result, result_hi, zero, carry, negative, overflow, div_zero, illegal}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    issue("add_1_2",   4'd0, 8'h01, 8'h02, 1, 8'h03, 8'h00, 6'b000000, 1'b1, 1'b0);
    issue("add_ff_1",  4'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 6'b110000, 1'b1, 1'b0);
    issue("sub_5_9",   4'd1, 8'h05, 8'h09, 1, 8'hFC, 8'h00, 6'b001000, 1'b1, 1'b0);
    issue("mul_200_3", 4'd6, 8'd200, 8'd3, 9, 8'h58, 8'h02, 6'b000100, 1'b1, 1'b0);
    issue("mul_15_17", 4'd6, 8'd15, 8'd17, 9, 8'hFF, 8'h00, 6'b000000, 1'b1, 1'b0);
    issue("div_100_7", 4'd7, 8'd100, 8'd7, 9, 8'd14, 8'h00, 6'b000000, 1'b1, 1'b0);
    issue("div_5_0",   4'd7, 8'd5, 8'd0, 1, 8'h00, 8'h00, 6'b100010, 1'b1, 1'b0);
    issue("mod_100_7", 4'd8, 8'd100, 8'd7, 9, 8'd2, 8'h00, 6'b000000, 1'b1, 1'b0);
    issue("div_held",  4'd7, 8'd100, 8'd7, 9, 8'd14, 8'h00, 6'b000000, 1'b1, 1'b1);
    drain();

    issue("xor_f0_ff", 4'd4, 8'hF0, 8'hFF, 1, 8'h0F, 8'h00, 6'b000000, 1'b1, 1'b0);
    issue("not_0f",    4'd5, 8'h0F, 8'h55, 1, 8'hF0, 8'h00, 6'b000000, 1'b1, 1'b0);
    drain();
    n = done_log.size();
    if (n >= 2) chk("back_to_back.gap", 32'(done_log[n-1] - done_log[n-2]), 32'd2);
    else begin
      checks++;
      errors++;
      $display("FAIL back_to_back.gap: only %0d done pulses seen, required at least 2", n);
    end

    issue("illegal_12", 4'd12, 8'h33, 8'h44, 1, 8'h00, 8'h00, 6'b000001, 1'b1, 1'b0);
    issue("and_aa_0f",  4'd2, 8'hAA, 8'h0F, 1, 8'h0A, 8'h00, 6'b000000, 1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
